// File: rtl/mfgate_prober.sv
// Multifunction-gate prober: walks {x,y} through 00,01,10,11, samples the gate
// output once per vector, then decodes the 4-bit response into the gate's function.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; probes parked at 00, busy low
// S_HOLD   | holding vector r_idx; down-counter runs to 0, then f_in is sampled
// S_FINISH | all four samples captured; publish sig/cls and pulse done

module mfgate_prober #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f_in,
    output logic       probe_x,
    output logic       probe_y,
    output logic       busy,
    output logic       done,
    output logic [3:0] sig,
    output logic [1:0] cls
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
            $error("mfgate_prober: SETTLE_CYCLES must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);

    localparam logic [1:0] CLS_PASS_X  = 2'd0;
    localparam logic [1:0] CLS_PASS_Y  = 2'd1;
    localparam logic [1:0] CLS_INV_X   = 2'd2;
    localparam logic [1:0] CLS_INVALID = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_idx;
    logic [7:0] r_cnt;
    logic [3:0] r_cap;
    logic       r_probe_x;
    logic       r_probe_y;
    logic       r_busy;
    logic       r_done;
    logic [3:0] r_sig;
    logic [1:0] r_cls;

    logic [1:0] w_idx_nxt;
    logic [1:0] w_cls_fin;

    function automatic logic [1:0] decode_cls(input logic [3:0] s);
        logic [1:0] c;
        case (s)
            4'b1100: c = CLS_PASS_X;
            4'b1010: c = CLS_PASS_Y;
            4'b0011: c = CLS_INV_X;
            default: c = CLS_INVALID;
        endcase
        return c;
    endfunction

    assign w_idx_nxt = r_idx + 2'd1;
    assign w_cls_fin = decode_cls(r_cap);

    // r_cap accumulates the partial signature so sig/cls only move on done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= 2'd0;
            r_cnt     <= 8'd0;
            r_cap     <= 4'b0000;
            r_probe_x <= 1'b0;
            r_probe_y <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sig     <= 4'b0000;
            r_cls     <= CLS_INVALID;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_HOLD;
                        r_idx     <= 2'd0;
                        r_cnt     <= SETTLE_LD;
                        r_cap     <= 4'b0000;
                        r_probe_x <= 1'b0;
                        r_probe_y <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        r_cap[r_idx] <= f_in;
                        if (r_idx != 2'd3) begin
                            r_idx     <= w_idx_nxt;
                            r_probe_x <= w_idx_nxt[1];
                            r_probe_y <= w_idx_nxt[0];
                            r_cnt     <= SETTLE_LD;
                        end else begin
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    r_sig     <= r_cap;
                    r_cls     <= w_cls_fin;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_probe_x <= 1'b0;
                    r_probe_y <= 1'b0;
                    r_idx     <= 2'd0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign probe_x = r_probe_x;
    assign probe_y = r_probe_y;
    assign busy    = r_busy;
    assign done    = r_done;
    assign sig     = r_sig;
    assign cls     = r_cls;

endmodule

// File: tb/tb_mfgate_prober.sv
// Bench for mfgate_prober: three instances (settle 2, 1, 255) probing a modelled
// gate; expected signatures are queued at start and checked by a done monitor.

module tb_mfgate_prober;

    logic       clk;
    logic       rst_n;
    logic [2:0] start_v;
    logic [2:0] px, py, busy_v, done_v;
    logic       f0, f1, f2;
    logic [3:0] sig_v [3];
    logic [1:0] cls_v [3];

    int         settle [3] = '{2, 1, 255};
    int         mode;
    logic [3:0] tt;
    int         tick;
    int         errors;
    int         checks;

    typedef struct {
        int         dut;
        logic [3:0] sig;
        logic [1:0] cls;
        int         due;
    } exp_t;

    exp_t       exp_q [$];
    exp_t       mon_e;
    logic [3:0] hold_sig [3];
    logic [1:0] hold_cls [3];

    // Gate under probe: modes 0..3 are the select settings, 4/5 stuck-at, 6 arbitrary table.
    function automatic logic gate_f(input int m, input logic x, input logic y, input logic [3:0] t);
        logic [1:0] v;
        v = {x, y};
        case (m)
            0: return x;
            1: return y;
            2: return y;
            3: return ~x;
            4: return 1'b0;
            5: return 1'b1;
            default: return t[v];
        endcase
    endfunction

    function automatic logic [1:0] cls_of(input logic [3:0] s);
        if (s == 4'b1100) return 2'd0;
        if (s == 4'b1010) return 2'd1;
        if (s == 4'b0011) return 2'd2;
        return 2'd3;
    endfunction

    assign f0 = gate_f(mode, px[0], py[0], tt);
    assign f1 = gate_f(mode, px[1], py[1], tt);
    assign f2 = gate_f(mode, px[2], py[2], tt);

    mfgate_prober #(.SETTLE_CYCLES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .f_in(f0),
        .probe_x(px[0]), .probe_y(py[0]), .busy(busy_v[0]), .done(done_v[0]),
        .sig(sig_v[0]), .cls(cls_v[0])
    );
    mfgate_prober #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .f_in(f1),
        .probe_x(px[1]), .probe_y(py[1]), .busy(busy_v[1]), .done(done_v[1]),
        .sig(sig_v[1]), .cls(cls_v[1])
    );
    mfgate_prober #(.SETTLE_CYCLES(255)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .f_in(f2),
        .probe_x(px[2]), .probe_y(py[2]), .busy(busy_v[2]), .done(done_v[2]),
        .sig(sig_v[2]), .cls(cls_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial tick = 0;
    always @(posedge clk) tick++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected results on done, otherwise sig/cls must hold.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (done_v[d]) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", int'(done_v[d]), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_dut", d, mon_e.dut);
                    chk("done_time", tick, mon_e.due);
                    chk("sig", int'(sig_v[d]), int'(mon_e.sig));
                    chk("cls", int'(cls_v[d]), int'(mon_e.cls));
                    hold_sig[d] = mon_e.sig;
                    hold_cls[d] = mon_e.cls;
                end
            end else begin
                chk("sig_hold", int'(sig_v[d]), int'(hold_sig[d]));
                chk("cls_hold", int'(cls_v[d]), int'(hold_cls[d]));
            end
        end
    end

    task automatic clear_hold();
        for (int d = 0; d < 3; d++) begin
            hold_sig[d] = 4'b0000;
            hold_cls[d] = 2'd3;
        end
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        chk({tag, "_px"}, int'(px[d]), 0);
        chk({tag, "_py"}, int'(py[d]), 0);
        chk({tag, "_busy"}, int'(busy_v[d]), 0);
    endtask

    task automatic push_exp(input int d, input int m, input logic [3:0] t, input int due);
        exp_t       e;
        logic [3:0] es;
        logic [1:0] v;
        for (int k = 0; k < 4; k++) begin
            v = 2'(k);
            es[k] = gate_f(m, v[1], v[0], t);
        end
        e.dut = d;
        e.sig = es;
        e.cls = cls_of(es);
        e.due = due;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int bound, input string tag);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
        chk({tag, "_timeout"}, exp_q.size(), 0);
    endtask

    // One run; if poke, start is re-asserted mid-run and must be ignored.
    task automatic do_run(input int d, input int m, input logic [3:0] t, input bit poke);
        int s;
        int lat;
        int e0;
        int vec;
        s = settle[d];
        lat = 4 * (s + 1) + 1;
        mode = m;
        tt = t;
        @(negedge clk);
        start_v[d] = 1'b1;
        @(posedge clk);
        #1 e0 = tick;
        push_exp(d, m, t, e0 + lat);
        for (int j = 1; j <= 4 * (s + 1); j++) begin
            @(negedge clk);
            start_v[d] = (poke && j == 5);
            vec = (j - 1) / (s + 1);
            chk("probe_vec", int'({px[d], py[d]}), vec);
            chk("busy_run", int'(busy_v[d]), 1);
        end
        start_v[d] = 1'b0;
        wait_drain(20, "run");
        check_idle_outputs(d, "post");
    endtask

    initial begin
        logic [3:0] rt;
        int         e0;
        int         rm;
        errors  = 0;
        checks  = 0;
        start_v = 3'b000;
        mode    = 0;
        tt      = 4'b0000;
        clear_hold();
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_idle_outputs(d, "rst");
            chk("rst_done", int'(done_v[d]), 0);
        end
        rst_n = 1'b1;

        // Idle with start low: nothing may happen.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) chk("idle_busy", int'(busy_v[d]), 0);
        end

        for (int m = 0; m < 6; m++) do_run(0, m, 4'b0000, 1'b0);
        do_run(0, 2, 4'b0000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            rt = 4'($urandom);
            rm = $urandom_range(0, 6);
            do_run(0, rm, rt, (i % 3) == 0);
        end

        // Back-to-back: start held high, each run accepted in its done cycle.
        mode = 1;
        tt = 4'b0000;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 e0 = tick;
        for (int k = 0; k < 3; k++) push_exp(0, 1, 4'b0000, e0 + 13 + k * 14);
        for (int i = 0; i < 60 && tick < e0 + 28; i++) @(negedge clk);
        chk("b2b_third_start", tick, e0 + 28);
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_drain(40, "b2b");

        // Reset mid-run: outputs drop before the next edge, no done issued.
        mode = 0;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_busy", int'(busy_v[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        clear_hold();
        check_idle_outputs(0, "midrst");
        chk("midrst_done", int'(done_v[0]), 0);
        chk("midrst_sig", int'(sig_v[0]), 0);
        chk("midrst_cls", int'(cls_v[0]), 3);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        do_run(0, 3, 4'b0000, 1'b0);

        for (int m = 0; m < 6; m++) do_run(1, m, 4'b0000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rt = 4'($urandom);
            do_run(1, 6, rt, 1'b0);
        end
        do_run(1, 0, 4'b0000, 1'b1);

        do_run(2, 0, 4'b0000, 1'b0);
        do_run(2, 3, 4'b0000, 1'b1);
        rt = 4'($urandom);
        do_run(2, 6, rt, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
